// File: rtl/element_shift_register.sv
// WIDTH-bit register with hold/load/shift/rotate/clear operations, serial in/out,
// and a saturating shift counter that flags when the contents have fully drained.
module element_shift_register #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic [CNT_W-1:0] shift_count,
    output logic             drained
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    op_e              op;
    logic [WIDTH-1:0] data_q, data_d;
    logic             so_q, so_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign op = op_e'(mode);

    // Counter sticks at WIDTH; shifting itself continues past saturation.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        data_d = data_q;
        so_d   = so_q;
        cnt_d  = cnt_q;
        if (enable) begin
            case (op)
                OP_HOLD: ;
                OP_LOAD: begin
                    data_d = data_in;
                    cnt_d  = '0;
                end
                OP_SHL: begin
                    data_d = {data_q[WIDTH-2:0], serial_in};
                    so_d   = data_q[WIDTH-1];
                    cnt_d  = cnt_inc;
                end
                OP_SHR: begin
                    data_d = {serial_in, data_q[WIDTH-1:1]};
                    so_d   = data_q[0];
                    cnt_d  = cnt_inc;
                end
                OP_ROL: begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    cnt_d  = cnt_inc;
                end
                OP_ROR: begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                    cnt_d  = cnt_inc;
                end
                OP_ASR: begin
                    data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    so_d   = data_q[0];
                    cnt_d  = cnt_inc;
                end
                OP_CLEAR: begin
                    data_d = '0;
                    so_d   = 1'b0;
                    cnt_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            so_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            so_q   <= so_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out         = data_q;
    assign serial_out  = so_q;
    assign shift_count = cnt_q;
    assign drained     = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_element_shift_register.sv
// Directed bench for element_shift_register: an 8-bit instance with a non-zero reset
// value and a 2-bit instance sharing clock, reset and control.
module tb_element_shift_register;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [2:0] mode;
    logic       serial_in;
    logic [7:0] data8;
    logic [1:0] data2;

    logic [7:0] out8;
    logic       so8;
    logic [3:0] cnt8;
    logic       dr8;
    logic [1:0] out2;
    logic       so2;
    logic [1:0] cnt2;
    logic       dr2;

    int total = 0;
    int bad   = 0;

    element_shift_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clock(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .data_in(data8), .serial_in(serial_in), .out(out8),
        .serial_out(so8), .shift_count(cnt8), .drained(dr8)
    );

    element_shift_register #(.WIDTH(2)) dut2 (
        .clock(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .data_in(data2), .serial_in(serial_in), .out(out2),
        .serial_out(so2), .shift_count(cnt2), .drained(dr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one operation, let the next rising edge take it, then sample 1ns later.
    task automatic do_op(input logic en, input logic [2:0] m, input logic [7:0] d,
                         input logic sin);
        enable    = en;
        mode      = m;
        data8     = d;
        serial_in = sin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] shl_exp [8];
        logic [7:0] so_seq;
        logic [7:0] asr_exp [3];
        shl_exp = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF};
        so_seq  = 8'b1000_0001;
        asr_exp = '{8'hC0, 8'hE0, 8'hF0};

        reset_n   = 1'b1;
        enable    = 1'b0;
        mode      = M_HOLD;
        data8     = '0;
        data2     = '0;
        serial_in = 1'b0;

        // Asynchronous reset mid-cycle, before the first clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("rst_out", out8, 8'hA5);
        check("rst_cnt", cnt8, 0);
        check("rst_drained", dr8, 0);
        check("rst_so", so8, 0);
        check("rst_out_w2", out2, 0);

        do_op(1'b1, M_SHL, 8'h00, 1'b1);
        check("rst_shl_out", out8, 8'hA5);
        check("rst_shl_cnt", cnt8, 0);
        reset_n = 1'b1;

        do_op(1'b1, M_LOAD, 8'b1000_0001, 1'b0);
        check("load81_out", out8, 8'h81);
        check("load81_cnt", cnt8, 0);
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, M_SHL, 8'h00, 1'b1);
            check($sformatf("shl%0d_out", i + 1), out8, shl_exp[i]);
            check($sformatf("shl%0d_so", i + 1), so8, so_seq[7 - i]);
            check($sformatf("shl%0d_cnt", i + 1), cnt8, i + 1);
            check($sformatf("shl%0d_dr", i + 1), dr8, (i == 7) ? 1 : 0);
        end
        do_op(1'b1, M_SHL, 8'h00, 1'b1);
        check("shl9_cnt", cnt8, 8);
        check("shl9_out", out8, 8'hFF);
        check("shl9_dr", dr8, 1);

        do_op(1'b1, M_HOLD, 8'h12, 1'b0);
        check("hold_out", out8, 8'hFF);
        check("hold_cnt", cnt8, 8);

        do_op(1'b1, M_LOAD, 8'h96, 1'b0);
        check("load96_cnt", cnt8, 0);
        check("load96_dr", dr8, 0);
        check("load96_so", so8, 1);
        for (int i = 0; i < 8; i++) do_op(1'b1, M_ROL, 8'h00, 1'b0);
        check("rol8_out", out8, 8'h96);
        check("rol8_cnt", cnt8, 8);
        check("rol8_dr", dr8, 1);
        check("rol8_so", so8, 1);
        do_op(1'b1, M_ROR, 8'h00, 1'b1);
        check("ror_out", out8, 8'h4B);
        check("ror_cnt", cnt8, 8);

        do_op(1'b1, M_LOAD, 8'h80, 1'b0);
        check("load80_out", out8, 8'h80);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, M_ASR, 8'h00, 1'b1);
            check($sformatf("asr%0d_out", i + 1), out8, asr_exp[i]);
            check($sformatf("asr%0d_so", i + 1), so8, 0);
        end
        check("asr_cnt", cnt8, 3);
        do_op(1'b1, M_SHR, 8'h00, 1'b0);
        check("shr_out", out8, 8'h78);
        check("shr_so", so8, 0);

        do_op(1'b1, M_LOAD, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) do_op(1'b0, M_SHL, 8'h00, 1'b1);
        check("dis_out", out8, 8'h3C);
        check("dis_cnt", cnt8, 0);
        do_op(1'b1, M_SHR, 8'h00, 1'b1);
        check("pre_clr_so", so8, 0);
        do_op(1'b1, M_SHL, 8'h00, 1'b0);
        check("pre_clr_out", out8, 8'h3C);
        check("pre_clr_so1", so8, 1);
        do_op(1'b1, M_CLEAR, 8'hFF, 1'b1);
        check("clr_out", out8, 8'h00);
        check("clr_cnt", cnt8, 0);
        check("clr_so", so8, 0);

        data2 = 2'b10;
        do_op(1'b1, M_LOAD, 8'h00, 1'b0);
        check("w2_load", out2, 2'b10);
        do_op(1'b1, M_SHR, 8'h00, 1'b1);
        check("w2_shr1_out", out2, 2'b11);
        check("w2_shr1_so", so2, 0);
        check("w2_shr1_cnt", cnt2, 1);
        check("w2_shr1_dr", dr2, 0);
        do_op(1'b1, M_SHR, 8'h00, 1'b1);
        check("w2_shr2_cnt", cnt2, 2);
        check("w2_shr2_dr", dr2, 1);
        check("w2_shr2_so", so2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
